time_set_ctrl: RTL

//  Edit controller for the clock's set-time datapath. While mode==0 it qualifies

---
 rtl/time_set_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: qualifies edit buttons, moves a field cursor over BCD shadow time
// registers and issues a one-cycle load strobe when the edited time is committed.
module time_set_ctrl #(
    parameter int HOLD_CYCLES   = 2500000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mode,
    input  logic        button_l,
    input  logic        button_r,
    input  logic        button_up,
    input  logic        button_down,
    input  logic        button_mid,
    input  logic [15:0] cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_sec,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic [2:0]  field,
    output logic        editing,
    output logic        load
);
    localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 2);
    localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP  = CW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT, WAIT_REL} state_t;
    state_t state;

    logic [2:0]    win, prev_win;
    logic [CW-1:0] cnt, c;
    logic          rep, ongoing, fire, up, clamp_pend, leap;
    logic [7:0]    dim;

    function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] lo,
                                       input logic [7:0] hi, input logic inc);
        logic [7:0] nx, pv;
        nx = (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
        pv = (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
        return inc ? ((v >= hi) ? lo : nx) : ((v <= lo) ? hi : pv);
    endfunction

    // a BCD year yy is a multiple of 4 iff (2*tens + units) is
    always_comb begin
        win = button_mid ? 3'd1 : button_up ? 3'd2 : button_down ? 3'd3 :
              button_l ? 3'd4 : button_r ? 3'd5 : 3'd0;
        ongoing = (win != 3'd0) && (win == prev_win);
        c = ongoing ? cnt + 1'b1 : CW'(win != 3'd0);
        fire = (win != 3'd0) && (c == ((ongoing && rep) ? REP : HOLD));
        up = (win == 3'd2);
        leap = year[4] ? (year[3:0] == 4'h2 || year[3:0] == 4'h6)
                       : (year[3:0] == 4'h0 || year[3:0] == 4'h4 || year[3:0] == 4'h8);
        dim = (month == 8'h02) ? (leap ? 8'h29 : 8'h28) :
              (month == 8'h04 || month == 8'h06 || month == 8'h09 || month == 8'h11) ? 8'h30 : 8'h31;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            year       <= 16'h2023;
            month      <= 8'h01;
            day        <= 8'h01;
            hour       <= 8'h00;
            minute     <= 8'h00;
            sec        <= 8'h00;
            field      <= 3'd0;
            editing    <= 1'b0;
            load       <= 1'b0;
            prev_win   <= 3'd0;
            cnt        <= '0;
            rep        <= 1'b0;
            clamp_pend <= 1'b0;
        end else begin
            prev_win <= win;
            // mid/l/r saturate at HOLD so they fire once; up/down restart for auto-repeat
            if (fire && (win == 3'd2 || win == 3'd3)) begin
                rep <= 1'b1;
                cnt <= '0;
            end else begin
                rep <= ongoing && rep;
                cnt <= (!(ongoing && rep) && c > HOLD) ? HOLD : c;
            end
            load       <= 1'b0;
            clamp_pend <= 1'b0;
            if (state != IDLE && mode != 4'd0) begin
                state   <= IDLE;
                editing <= 1'b0;
                field   <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        year   <= cur_year;
                        month  <= cur_month;
                        day    <= cur_day;
                        hour   <= cur_hour;
                        minute <= cur_minute;
                        sec    <= cur_sec;
                        field  <= 3'd0;
                        if (mode == 4'd0) begin
                            state   <= EDIT;
                            editing <= 1'b1;
                        end
                    end
                    EDIT: begin
                        if (clamp_pend && day > dim) day <= dim;
                        if (fire) begin
                            case (win)
                                3'd1: begin
                                    state <= COMMIT;
                                    load  <= 1'b1;
                                end
                                3'd2, 3'd3: begin
                                    case (field)
                                        3'd0: begin
                                            year       <= {8'h20, step(year[7:0], 8'h00, 8'h99, up)};
                                            clamp_pend <= 1'b1;
                                        end
                                        3'd1: begin
                                            month      <= step(month, 8'h01, 8'h12, up);
                                            clamp_pend <= 1'b1;
                                        end
                                        3'd2:    day    <= step(day, 8'h01, dim, up);
                                        3'd3:    hour   <= step(hour, 8'h00, 8'h23, up);
                                        3'd4:    minute <= step(minute, 8'h00, 8'h59, up);
                                        default: sec    <= step(sec, 8'h00, 8'h59, up);
                                    endcase
                                end
                                3'd4:    field <= (field == 3'd5) ? 3'd0 : field + 3'd1;
                                3'd5:    field <= (field == 3'd0) ? 3'd5 : field - 3'd1;
                                default: ;
                            endcase
                        end
                    end
                    COMMIT:  state <= WAIT_REL;
                    default: if (!button_mid) state <= EDIT;
                endcase
            end
        end
    end
endmodule
